// File: rtl/sram_like_port_arbiter_pkg.sv
// Shared ids, access sizes and lock record for the IF/MEM memory-port arbiter.
package sram_like_port_arbiter_pkg;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic vld;
    logic id;
  } lock_t;

endpackage

// File: rtl/arb_id_fifo.sv
// Requester-id FIFO for outstanding transactions; head is visible with no added delay.
// Push is ignored while full and pop while empty. Full and empty come from the registered count.
module arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push_vld,
  input  logic i_push_dat,
  input  logic i_pop_vld,
  output logic o_full,
  output logic o_empty,
  output logic o_head_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign w_push     = i_push_vld && !o_full;
  assign w_pop      = i_pop_vld && !o_empty;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/sram_like_port_arbiter.sv
// Shares one SRAM-like port between fetch and data; requests and responses pass with no added latency.
// A refused request is locked until accepted; mem_req drops while MAX_OUT transactions are outstanding.
module sram_like_port_arbiter
  import sram_like_port_arbiter_pkg::*;
#(
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  lock_t         r_lock;
  logic [SW-1:0] r_starve_cnt;
  logic          w_grant;
  logic          w_mem_req;
  logic          w_accept;
  logic          w_resp;
  logic          w_full;
  logic          w_empty;
  logic          w_head;

  always_comb begin
    w_grant = ID_INST;
    if (r_lock.vld) begin
      w_grant = r_lock.id;
    end else if (inst_req && (r_starve_cnt == SW'(STARVE_LIMIT))) begin
      w_grant = ID_INST;
    end else if (data_req) begin
      w_grant = ID_DATA;
    end
  end

  assign w_mem_req = (inst_req || data_req) && !w_full && !reset;
  assign w_accept  = w_mem_req && mem_addr_ok;
  assign w_resp    = mem_data_ok && !w_empty && !reset;

  assign mem_req   = w_mem_req;
  assign mem_wr    = !reset && (w_grant == ID_DATA) && data_wr;
  assign mem_size  = reset ? 2'd0 : ((w_grant == ID_DATA) ? data_size : SIZE_WORD);
  assign mem_addr  = (w_grant == ID_DATA) ? data_addr : inst_addr;
  assign mem_wdata = data_wdata;

  assign inst_addr_ok = w_accept && (w_grant == ID_INST);
  assign data_addr_ok = w_accept && (w_grant == ID_DATA);
  assign inst_data_ok = w_resp && (w_head == ID_INST);
  assign data_data_ok = w_resp && (w_head == ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock <= '0;
    end else if (w_accept) begin
      r_lock <= '0;
    end else if (w_mem_req) begin
      r_lock <= '{vld: 1'b1, id: w_grant};
    end
  end

  // Counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk) begin
    if (reset || !inst_req) begin
      r_starve_cnt <= '0;
    end else if (w_accept && (w_grant == ID_INST)) begin
      r_starve_cnt <= '0;
    end else if (w_accept && (r_starve_cnt != SW'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

  arb_id_fifo #(
    .DEPTH(MAX_OUT)
  ) u_id_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push_vld (w_accept),
    .i_push_dat (w_grant),
    .i_pop_vld  (w_resp),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head_dat (w_head)
  );

endmodule

// File: tb/tb_sram_like_port_arbiter.sv
// Drives directed and random traffic against a queue-based model; a separate monitor scores responses.
module tb_sram_like_port_arbiter;
  import sram_like_port_arbiter_pkg::*;

  localparam int MAX_OUT      = 4;
  localparam int STARVE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [1:0]  data_size;
  logic        mem_addr_ok, mem_data_ok;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;

  always #5 clk = ~clk;

  sram_like_port_arbiter #(
    .MAX_OUT(MAX_OUT),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] rdata;
  } resp_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  resp_t exp_q[$];
  logic  pend_q[$];
  int    grant_log[$];
  int    lock_who = -1;
  int    data_run = 0;
  bit    last_inst_acc = 0;
  bit    last_data_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are already applied (at the falling edge); check, advance the model, move to the next falling edge.
  task automatic do_cycle();
    bit full, ereq, acc;
    int who;
    #1;
    if (reset) begin
      chk("rst_mem_req", mem_req, 0);
      chk("rst_inst_addr_ok", inst_addr_ok, 0);
      chk("rst_data_addr_ok", data_addr_ok, 0);
      chk("rst_inst_data_ok", inst_data_ok, 0);
      chk("rst_data_data_ok", data_data_ok, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_size", mem_size, 0);
      pend_q.delete();
      lock_who = -1;
      data_run = 0;
      last_inst_acc = 0;
      last_data_acc = 0;
    end else begin
      full = (pend_q.size() == MAX_OUT);
      ereq = (inst_req || data_req) && !full;
      if (lock_who >= 0)                            who = lock_who;
      else if (inst_req && data_run == STARVE_LIMIT) who = 0;
      else if (data_req)                             who = 1;
      else                                           who = 0;
      acc = ereq && mem_addr_ok;
      chk("mem_req", mem_req, ereq);
      if (ereq) chk("mem_addr", mem_addr, (who == 1) ? data_addr : inst_addr);
      chk("mem_wr", mem_wr, (who == 1) ? data_wr : 1'b0);
      chk("mem_size", mem_size, (who == 1) ? data_size : 2'd2);
      chk("mem_wdata", mem_wdata, data_wdata);
      chk("inst_addr_ok", inst_addr_ok, acc && who == 0);
      chk("data_addr_ok", data_addr_ok, acc && who == 1);
      if (mem_data_ok) begin
        if (pend_q.size() > 0) begin
          exp_q.push_back('{id: pend_q.pop_front(), rdata: mem_rdata});
        end else begin
          chk("empty_rsp_inst_data_ok", inst_data_ok, 0);
          chk("empty_rsp_data_data_ok", data_data_ok, 0);
        end
      end
      if (acc) begin
        pend_q.push_back(who[0]);
        grant_log.push_back(who);
      end
      if (acc)       lock_who = -1;
      else if (ereq) lock_who = who;
      if (!inst_req)                 data_run = 0;
      else if (acc && who == 0)      data_run = 0;
      else if (acc && data_run < STARVE_LIMIT) data_run++;
      last_inst_acc = acc && who == 0;
      last_data_acc = acc && who == 1;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                         input bit aok, input bit dok, input logic [31:0] rd);
    inst_req = ir; inst_addr = ia;
    data_req = dr; data_addr = da; data_wr = 1'b0; data_size = SIZE_WORD;
    data_wdata = 32'h5A5A_0000 ^ da;
    mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && pend_q.size() > 0; i++) begin
      set_req(0, 0, 0, 0, 1, 1, $urandom);
      do_cycle();
    end
    chk("drain_done", pend_q.size(), 0);
    set_req(0, 0, 0, 0, 0, 0, 0);
    do_cycle();
  endtask

  task automatic rand_inputs();
    if (!inst_req || last_inst_acc) begin
      inst_req  = ($urandom_range(0, 99) < 60);
      inst_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!data_req || last_data_acc) begin
      data_req   = ($urandom_range(0, 99) < 60);
      data_addr  = $urandom;
      data_wr    = $urandom_range(0, 1);
      data_size  = 2'($urandom_range(0, 2));
      data_wdata = $urandom;
    end
    mem_addr_ok = ($urandom_range(0, 99) < 70);
    mem_data_ok = (pend_q.size() > 0) && ($urandom_range(0, 1) == 1);
    mem_rdata   = $urandom;
  endtask

  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (inst_data_ok || data_data_ok) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: inst_data_ok=%b data_data_ok=%b with nothing expected at %0t",
                   inst_data_ok, data_data_ok, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_one_hot", inst_data_ok && data_data_ok, 0);
          chk("rsp_id", data_data_ok, e.id);
          chk("rsp_rdata", e.id ? data_rdata : inst_rdata, e.rdata);
        end
      end
    end
  end

  initial begin : stimulus
    int exp_seq[8];
    exp_seq = '{1, 1, 1, 0, 1, 1, 1, 0};
    reset = 1'b1;
    set_req(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_cycle();
    reset = 1'b1;
    set_req(1, 32'h1000, 1, 32'h2000, 1, 1, 32'hDEAD_BEEF);
    do_cycle();
    reset = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0);
    do_cycle();

    // Both requesters held with the memory always ready: data first, fetch forced every fourth grant.
    grant_log.delete();
    for (int i = 0; i < 8; i++) begin
      set_req(1, 32'h1000, 1, 32'h2000, 1, pend_q.size() > 0, $urandom);
      do_cycle();
    end
    chk("grant_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk($sformatf("grant_seq[%0d]", i), grant_log[i], exp_seq[i]);
    drain();

    // One fetch then one load, answered in order.
    set_req(1, 32'h1000, 0, 0, 1, 0, 0);          do_cycle();
    set_req(0, 0, 1, 32'h2000, 1, 0, 0);          do_cycle();
    set_req(0, 0, 0, 0, 0, 1, 32'hAAAA_0000);     do_cycle();
    set_req(0, 0, 0, 0, 0, 1, 32'hBBBB_0000);     do_cycle();
    set_req(0, 0, 0, 0, 0, 0, 0);                 do_cycle();

    // Fill to MAX_OUT, then free one slot; mem_req comes back one cycle later.
    for (int i = 0; i < 6; i++) begin
      set_req(1, 32'h1100 + 32'(i * 4), 1, 32'h2100 + 32'(i * 4), 1, 0, 0);
      do_cycle();
    end
    set_req(1, 32'h1200, 1, 32'h2200, 1, 1, 32'h1234_5678);
    do_cycle();
    set_req(1, 32'h1200, 1, 32'h2200, 1, 0, 0);
    do_cycle();
    drain();

    // Refused fetch stays locked while data_req rises.
    grant_log.delete();
    set_req(1, 32'h1000, 0, 0, 0, 0, 0);          do_cycle();
    set_req(1, 32'h1000, 1, 32'h2000, 0, 0, 0);   do_cycle();
    set_req(1, 32'h1000, 1, 32'h2000, 0, 0, 0);   do_cycle();
    set_req(1, 32'h1000, 1, 32'h2000, 1, 0, 0);   do_cycle();
    set_req(0, 0, 1, 32'h2000, 1, 0, 0);          do_cycle();
    chk("lock_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("lock_grant0", grant_log[0], 0);
      chk("lock_grant1", grant_log[1], 1);
    end
    drain();

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      do_cycle();
    end
    drain();

    // Reset with two outstanding; a late response must be ignored.
    set_req(1, 32'h1000, 0, 0, 1, 0, 0);          do_cycle();
    set_req(0, 0, 1, 32'h2000, 1, 0, 0);          do_cycle();
    chk("pre_reset_outstanding", pend_q.size(), 2);
    reset = 1'b1;
    set_req(0, 0, 0, 0, 0, 0, 0);                 do_cycle();
    reset = 1'b0;
    set_req(0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);     do_cycle();
    set_req(0, 0, 1, 32'h3000, 1, 0, 0);          do_cycle();
    drain();

    repeat (3) do_cycle();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_like_port_arbiter.md
Name: sram_like_port_arbiter

Overview:
Shares one SRAM-like memory port between the IF-stage instruction fetch and the MEM-stage data access.
- Arbitrates request handshakes between the two requesters.
- Tracks outstanding transactions in order.
- Routes each mem_data_ok/mem_rdata back to the requester that issued it.
- Sits between the CPU pipeline and the SRAM-like-to-AXI bridge. WB-stage data_data_ok arrives through this block.

Parameters:
MAX_OUT, 4, max accepted-but-unanswered transactions; power of 2, >=2
STARVE_LIMIT, 3, consecutive data grants while inst_req pending before one forced inst grant

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
inst_req  in  1  fetch request (read-only, word size)
inst_addr  in  32  fetch address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch data valid this cycle
inst_rdata  out  32  fetch read data
data_req  in  1  data request
data_wr  in  1  1=store, 0=load
data_size  in  2  0=byte, 1=half, 2=word
data_addr  in  32  data address
data_wdata  in  32  store data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  load data returned / store done this cycle
data_rdata  out  32  load data
mem_req  out  1  request to memory side
mem_wr  out  1  write flag (0 when inst granted)
mem_size  out  2  size (2 when inst granted)
mem_addr  out  32  address of granted requester
mem_wdata  out  32  store data (data_wdata even when inst granted)
mem_addr_ok  in  1  memory accepted request
mem_data_ok  in  1  memory response valid
mem_rdata  in  32  memory response data

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Request path is combinational, zero added latency. mem_req = (inst_req|data_req) && !full && !reset. Accept = mem_req && mem_addr_ok.
- Grant: a held lock takes precedence. Without a lock, data wins over inst. Exception: inst wins when inst_req and starve_cnt == STARVE_LIMIT.
- Lock register: set with the grantee id when mem_req && !mem_addr_ok. Cleared on accept. mem_* stay on the locked requester until accept.
- Requesters hold req/addr/wdata until their addr_ok; the block does not buffer requests.
- inst_addr_ok = accept && grant==INST. data_addr_ok = accept && grant==DATA.
- starve_cnt: +1 on a data accept while inst_req is high, saturating at STARVE_LIMIT. Cleared on inst accept or when inst_req is low.
- ID FIFO, depth MAX_OUT, 1-bit entries:
  - Push grant id on accept; pop on mem_data_ok && !empty.
  - Push and pop in the same cycle leaves count unchanged.
  - full = (count == MAX_OUT), from the registered count only; there is no same-cycle bypass.
  - Pointers wrap modulo MAX_OUT.
- Response routing is combinational:
  - inst_data_ok = mem_data_ok && !empty && head==INST.
  - data_data_ok = mem_data_ok && !empty && head==DATA.
  - inst_rdata = data_rdata = mem_rdata.
- mem_data_ok while empty: ignored, no *_data_ok generated; the verification bench flags it as an error.
- Responses return strictly in acceptance order; the memory side guarantees in-order completion.
- Reset values: count=0, pointers=0, lock clear, starve_cnt=0. All outputs 0 while reset is high; mem_addr/wdata/rdata are don't-care.
- Reset mid-operation drops every outstanding transaction. Responses arriving afterwards hit the empty case and are ignored.

Decomposition:
- Shared package: ID_INST=1'b0, ID_DATA=1'b1, SIZE_BYTE/HALF/WORD = 2'd0/1/2.
- One sub-module, arb_id_fifo: parameterised depth, 1-bit width, with push, pop, full, empty, head outputs.

Test Plan:
1. inst_req=data_req=1, data_addr=0x2000, inst_addr=0x1000, mem_addr_ok=1 -> mem_addr=0x2000, data_addr_ok=1, inst_addr_ok=0.
2. Inst accepted @0x1000, then data load @0x2000; mem_data_ok with 0xAAAA0000 then 0xBBBB0000 -> inst_data_ok+0xAAAA0000, then data_data_ok+0xBBBB0000.
3. Four accepts with no response -> mem_req=0 and both addr_ok=0. One mem_data_ok -> mem_req returns next cycle, not same cycle.
4. inst_req and data_req held, mem_addr_ok=1 every cycle -> grant sequence D,D,D,I,D,D,D,I.
5. Inst granted with mem_addr_ok=0 for 3 cycles while data_req rises at cycle 1 -> mem_addr stays 0x1000. Inst accepted at cycle 3; data granted cycle 4.
6. Two outstanding, reset high 1 cycle, then mem_data_ok=1 -> inst_data_ok=data_data_ok=0; next request is accepted normally.
